// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage in front of the data memory.
// Accepts one request at a time from execute, checks it for illegal mode,
// misalignment and address range, then drives the memory for one access.
// Load results go to writeback over a valid/ready handshake. A faulting
// request gets a one-cycle fault pulse and never touches memory.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   req_valid / req_ready      request handshake from execute
//   req_is_store, req_funct3,  request payload: direction, access mode,
//   req_addr, req_wdata,       byte address, LSB-justified store data,
//   req_rd                     load destination register
//   mem_rd_en, mem_wr_en,      memory strobes (never both high)
//   mem_addr, mem_acc_mode,    address, mode and store data to memory,
//   mem_wdata                  held stable for the whole access
//   mem_rdata                  extended read data from memory
//   resp_valid / resp_ready    load result handshake to writeback
//   resp_data, resp_rd         load result and destination register
//   fault_valid, fault_cause,  one-cycle fault pulse: 01 misaligned,
//   fault_addr                 10 out of range, 11 illegal mode
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES   = 100,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_acc_mode,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        fault_valid,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MEM,
        S_WAIT,
        S_RESP,
        S_FAULT
    } state_t;

    state_t             state;
    logic               lat_store;
    logic [2:0]         lat_funct3;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [4:0]         lat_rd;
    logic [CNT_W-1:0]   wait_cnt;

    logic [2:0]         size_c;
    logic               illegal_c;
    logic               misaligned_c;
    logic               range_c;
    logic [ADDR_W:0]    last_byte_c;
    logic [1:0]         cause_c;

    // Fault classification of the latched request; the extra address bit
    // keeps the last-byte sum from wrapping near the top of the address space.
    always_comb begin
        size_c       = 3'd1;
        cause_c      = 2'b00;
        case (lat_funct3[1:0])
            2'b01:   size_c = 3'd2;
            2'b10:   size_c = 3'd4;
            default: size_c = 3'd1;
        endcase
        illegal_c    = (lat_funct3 == 3'b011) || (lat_funct3[2:1] == 2'b11) ||
                       (lat_store && lat_funct3[2]);
        misaligned_c = ((lat_funct3[1:0] == 2'b01) && lat_addr[0]) ||
                       ((lat_funct3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
        last_byte_c  = {1'b0, lat_addr} + (ADDR_W+1)'(size_c) - (ADDR_W+1)'(1);
        range_c      = last_byte_c > (ADDR_W+1)'(MEM_BYTES - 1);
        if (illegal_c)
            cause_c = 2'b11;
        else if (misaligned_c)
            cause_c = 2'b01;
        else if (range_c)
            cause_c = 2'b10;
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            lat_store    <= 1'b0;
            lat_funct3   <= 3'b000;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_rd       <= 5'd0;
            wait_cnt     <= '0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= 32'd0;
            mem_acc_mode <= 3'b000;
            mem_wdata    <= 32'd0;
            resp_valid   <= 1'b0;
            resp_data    <= 32'd0;
            resp_rd      <= 5'd0;
            fault_valid  <= 1'b0;
            fault_cause  <= 2'b00;
            fault_addr   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_store  <= req_is_store;
                        lat_funct3 <= req_funct3;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        lat_rd     <= req_rd;
                        req_ready  <= 1'b0;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cause_c != 2'b00) begin
                        fault_valid <= 1'b1;
                        fault_cause <= cause_c;
                        fault_addr  <= lat_addr;
                        state       <= S_FAULT;
                    end else begin
                        mem_addr     <= lat_addr;
                        mem_acc_mode <= lat_funct3;
                        mem_wdata    <= lat_wdata;
                        mem_wr_en    <= lat_store;
                        mem_rd_en    <= ~lat_store;
                        state        <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (lat_store) begin
                        mem_wr_en <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else if (WAIT_CYCLES == 0) begin
                        mem_rd_en  <= 1'b0;
                        resp_data  <= mem_rdata;
                        resp_rd    <= lat_rd;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        // Counts down to zero; data is taken on the zero cycle.
                        wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        mem_rd_en  <= 1'b0;
                        resp_data  <= mem_rdata;
                        resp_rd    <= lat_rd;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    fault_valid <= 1'b0;
                    req_ready   <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl. Two instances run side by
// side, one with no memory wait states and one with three. Each has its own
// byte-array memory, random stimulus, a reference model computing the
// expected outcome of every request, and a monitor checking what the DUT
// presents against the queue of expectations.
module tb_lsu_ctrl;

    localparam int unsigned MEM_BYTES = 100;
    localparam int K_STORE = 0;
    localparam int K_LOAD  = 1;
    localparam int K_FAULT = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [2:0]  mode;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  cause;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen; the interval after edge k reads cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int dut, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL dut%0d %s: got 0x%08h want 0x%08h (t=%0t)", dut, name, act, req, $time);
        end
    endtask

    task automatic unexpected(input string name, input int dut, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL dut%0d %s: got activity at 0x%08h want none (t=%0t)", dut, name, act, $time);
    endtask

    // Sign/zero extension a memory applies for each access mode.
    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'd0, raw[7:0]};
            3'b101:  return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int unsigned W = 3 * g;

        logic        rst;
        logic        req_valid;
        logic        req_ready;
        logic        req_is_store;
        logic [2:0]  req_funct3;
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic [4:0]  req_rd;
        logic        mem_rd_en;
        logic        mem_wr_en;
        logic [31:0] mem_addr;
        logic [2:0]  mem_acc_mode;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic        resp_valid;
        logic        resp_ready;
        logic [31:0] resp_data;
        logic [4:0]  resp_rd;
        logic        fault_valid;
        logic [1:0]  fault_cause;
        logic [31:0] fault_addr;

        lsu_ctrl #(.MEM_BYTES(MEM_BYTES), .WAIT_CYCLES(W)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid),
            .req_ready    (req_ready),
            .req_is_store (req_is_store),
            .req_funct3   (req_funct3),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .req_rd       (req_rd),
            .mem_rd_en    (mem_rd_en),
            .mem_wr_en    (mem_wr_en),
            .mem_addr     (mem_addr),
            .mem_acc_mode (mem_acc_mode),
            .mem_wdata    (mem_wdata),
            .mem_rdata    (mem_rdata),
            .resp_valid   (resp_valid),
            .resp_ready   (resp_ready),
            .resp_data    (resp_data),
            .resp_rd      (resp_rd),
            .fault_valid  (fault_valid),
            .fault_cause  (fault_cause),
            .fault_addr   (fault_addr)
        );

        logic [7:0]  env_mem [MEM_BYTES];
        logic [7:0]  ref_mem [MEM_BYTES];
        int unsigned rd_cnt;
        bit          stall = 1'b0;
        bit          done  = 1'b0;
        bit          resp_open = 1'b0;
        exp_t        q[$];

        // Memory with W wait states: data is only correct on the last read cycle.
        always_comb begin
            logic [31:0] raw;
            raw = 32'd0;
            for (int i = 0; i < 4; i++)
                if (mem_addr < 32'(MEM_BYTES - i))
                    raw[8*i +: 8] = env_mem[int'(mem_addr) + i];
            mem_rdata = ext_load(mem_acc_mode, raw);
            if (!(mem_rd_en && rd_cnt == W))
                mem_rdata = ~mem_rdata;
        end

        always @(posedge clk or posedge rst) begin
            if (rst)
                rd_cnt <= 0;
            else
                rd_cnt <= mem_rd_en ? rd_cnt + 1 : 0;
        end

        always @(posedge clk) begin
            if (!rst && mem_wr_en && mem_addr < 32'(MEM_BYTES)) begin
                for (int i = 0; i < acc_size(mem_acc_mode); i++)
                    if (int'(mem_addr) + i < int'(MEM_BYTES))
                        env_mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
            end
        end

        always @(posedge clk) begin
            #1;
            resp_ready = !stall && ($urandom_range(0, 2) != 0);
        end

        // Monitor: every DUT action must match the head of the expectation queue.
        always @(negedge clk) begin
            exp_t e;
            if (!rst) begin
                chk("rd_wr_exclusive", g, 32'(mem_rd_en && mem_wr_en), 32'd0);
                if (mem_wr_en) begin
                    if (q.size() == 0 || q[0].kind != K_STORE)
                        unexpected("unexpected_store", g, mem_addr);
                    else begin
                        e = q.pop_front();
                        chk("store_cycle", g, 32'(cyc), 32'(e.due));
                        chk("store_addr", g, mem_addr, e.addr);
                        chk("store_mode", g, 32'(mem_acc_mode), 32'(e.mode));
                        chk("store_wdata", g, mem_wdata, e.data);
                    end
                end
                if (mem_rd_en) begin
                    if (q.size() == 0 || q[0].kind != K_LOAD)
                        unexpected("unexpected_read", g, mem_addr);
                    else begin
                        chk("read_addr", g, mem_addr, q[0].addr);
                        chk("read_mode", g, 32'(mem_acc_mode), 32'(q[0].mode));
                        chk("read_len", g, 32'(rd_cnt <= W), 32'd1);
                    end
                end
                if (fault_valid) begin
                    if (q.size() == 0 || q[0].kind != K_FAULT)
                        unexpected("unexpected_fault", g, fault_addr);
                    else begin
                        e = q.pop_front();
                        chk("fault_cycle", g, 32'(cyc), 32'(e.due));
                        chk("fault_cause", g, 32'(fault_cause), 32'(e.cause));
                        chk("fault_addr", g, fault_addr, e.addr);
                    end
                end
                if (resp_valid) begin
                    if (q.size() == 0 || q[0].kind != K_LOAD)
                        unexpected("unexpected_resp", g, resp_data);
                    else begin
                        if (!resp_open)
                            chk("resp_cycle", g, 32'(cyc), 32'(q[0].due));
                        chk("resp_data", g, resp_data, q[0].data);
                        chk("resp_rd", g, 32'(resp_rd), 32'(q[0].rd));
                        chk("busy_ready", g, 32'(req_ready), 32'd0);
                        if (resp_ready) begin
                            void'(q.pop_front());
                            resp_open = 1'b0;
                        end else
                            resp_open = 1'b1;
                    end
                end
            end
        end

        // Reference model plus driver for one request. With rst_abort set the
        // request is killed by reset during its memory cycle.
        task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [4:0] rd, input bit rst_abort);
            exp_t        e;
            int          sz;
            int          n;
            bit          ill, mis, rng;
            logic [31:0] raw;
            sz  = acc_size(f3);
            ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && (f3 == 3'd4 || f3 == 3'd5));
            mis = (a % 32'(sz)) != 0;
            rng = (longint'(a) + longint'(sz)) > longint'(MEM_BYTES);
            e.kind = K_FAULT; e.addr = a; e.mode = f3; e.data = 32'd0; e.rd = rd; e.cause = 2'b00; e.due = 0;
            if (ill)
                e.cause = 2'b11;
            else if (mis)
                e.cause = 2'b01;
            else if (rng)
                e.cause = 2'b10;
            else if (st) begin
                e.kind = K_STORE;
                e.data = wd;
                if (!rst_abort)
                    for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end else begin
                e.kind = K_LOAD;
                raw = 32'd0;
                for (int i = 0; i < sz; i++) raw = raw | (32'(ref_mem[int'(a) + i]) << (8 * i));
                e.data = ext_load(f3, raw);
            end

            @(posedge clk); #1;
            req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
            req_addr = a; req_wdata = wd; req_rd = rd;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!req_ready && n < 200);
            if (!req_ready) begin
                unexpected("accept_timeout", g, a);
                req_valid = 1'b0;
                return;
            end
            e.due = cyc + 1 + ((e.kind == K_LOAD) ? 2 + int'(W) : 1);
            q.push_back(e);

            @(posedge clk); #1;
            req_valid = 1'b0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
            if (rst_abort) begin
                @(negedge clk);
                @(negedge clk);
                #1 rst = 1'b1;
                #1 chk("rst_wr_drop", g, 32'(mem_wr_en), 32'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("post_rst_ready", g, 32'(req_ready), 32'd1);
                chk("post_rst_strobes", g, 32'({mem_rd_en, mem_wr_en, resp_valid, fault_valid}), 32'd0);
                chk("post_rst_addr", g, mem_addr, 32'd0);
                chk("post_rst_wdata", g, mem_wdata, 32'd0);
                chk("post_rst_resp", g, resp_data | fault_addr, 32'd0);
            end else begin
                // A valid pulse while busy must be ignored.
                @(posedge clk); #1 req_valid = 1'($urandom);
                @(posedge clk); #1 req_valid = 1'b0;
            end
        endtask

        initial begin
            logic [2:0]  legal [5];
            logic [2:0]  f3;
            logic [31:0] a;
            int          n;
            legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            for (int i = 0; i < int'(MEM_BYTES); i++) begin
                ref_mem[i] = 8'($urandom);
                env_mem[i] = ref_mem[i];
            end
            rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
            req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("reset_ready", g, 32'(req_ready), 32'd1);
            chk("reset_strobes", g, 32'({mem_rd_en, mem_wr_en, resp_valid, fault_valid}), 32'd0);

            issue(1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 5'd0, 1'b0);
            stall = 1'b1;
            issue(1'b0, 3'b000, 32'd8, 32'd0, 5'd5, 1'b0);
            n = 0;
            while (!resp_valid && n < 50) begin @(negedge clk); n++; end
            repeat (4) @(negedge clk);
            stall = 1'b0;
            issue(1'b0, 3'b001, 32'd3, 32'd0, 5'd1, 1'b0);
            issue(1'b0, 3'b010, 32'd97, 32'd0, 5'd2, 1'b0);
            issue(1'b1, 3'b100, 32'd0, 32'h12, 5'd0, 1'b0);
            issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'd0, 5'd3, 1'b0);
            issue(1'b0, 3'b010, 32'hFFFFFFFC, 32'd0, 5'd3, 1'b0);
            issue(1'b0, 3'b010, 32'd4, 32'd0, 5'd4, 1'b0);
            issue(1'b0, 3'b010, 32'd96, 32'd0, 5'd6, 1'b0);
            issue(1'b0, 3'b101, 32'd98, 32'd0, 5'd7, 1'b0);
            issue(1'b0, 3'b100, 32'd99, 32'd0, 5'd8, 1'b0);
            issue(1'b0, 3'b001, 32'd100, 32'd0, 5'd9, 1'b0);

            for (int k = 0; k < 150; k++) begin
                f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
                case ($urandom_range(0, 9))
                    0:       a = $urandom;
                    1:       a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
                    2, 3:    a = 32'($urandom_range(0, MEM_BYTES / 4)) * 32'd4;
                    default: a = 32'($urandom_range(0, MEM_BYTES + 3));
                endcase
                issue(1'($urandom), f3, a, $urandom, 5'($urandom), 1'b0);
            end

            n = 0;
            while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
            chk("drain", g, 32'(q.size()), 32'd0);

            issue(1'b1, 3'b010, 32'd20, 32'hCAFEF00D, 5'd0, 1'b1);
            issue(1'b0, 3'b010, 32'd20, 32'd0, 5'd10, 1'b0);
            n = 0;
            while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
            chk("final_drain", g, 32'(q.size()), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_env[0].done && g_env[1].done) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_env[0].done && g_env[1].done)) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got done=%b%b want 11", g_env[1].done, g_env[0].done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
